// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions: NOP encoding, PC step, instruction width, fetch FSM states.
package if_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a fetch, otherwise holds.
// One edge from load/flush to output; flush wins over load.
module if_fetch_unit_if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] instr_d,
  input  logic [PC_WIDTH-1:0]    npc_d,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    npc,
  output logic                   valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= INSTR_WIDTH'(NOP_INSTR);
      npc   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= INSTR_WIDTH'(NOP_INSTR);
      npc   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      npc   <= npc_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select, BOOT/RUN FSM and fetch counter.
// Instruction at pc appears in IF/ID one edge later; stall freezes everything, branch flushes.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          INSTR_WIDTH = INSTR_W,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_npc,
  output logic                   ifid_valid,
  output logic [CNT_WIDTH-1:0]   fetch_cnt
);

  fetch_state_e         state, state_nxt;
  logic [PC_WIDTH-1:0]  pc, pc_nxt, pc_plus4;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 id_load, id_flush;

  assign pc_plus4  = pc + PC_WIDTH'(PC_STEP);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      fetch_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      fetch_cnt <= cnt_nxt;
    end
  end

  // Branch outranks stall; BOOT ignores both and just emits a bubble.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = fetch_cnt;
    id_load   = 1'b0;
    id_flush  = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        id_flush  = 1'b1;
      end
      RUN: begin
        if (branch_taken) begin
          pc_nxt   = branch_target & ~PC_WIDTH'(3);
          id_flush = 1'b1;
        end else if (!stall) begin
          pc_nxt  = pc_plus4;
          id_load = 1'b1;
          if (!(&fetch_cnt)) cnt_nxt = fetch_cnt + CNT_WIDTH'(1);
        end
      end
    endcase
  end

  if_fetch_unit_if_id_reg #(
    .PC_WIDTH   (PC_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (id_load),
    .flush  (id_flush),
    .instr_d(imem_rdata),
    .npc_d  (pc_plus4),
    .instr  (ifid_instr),
    .npc    (ifid_npc),
    .valid  (ifid_valid)
  );

endmodule
